loop_sram_ctrl: RTL and testbench

Sequences the external 16-bit SRAM as a single-track looper buffer for the audio chain. Runs on the BCLK domain and is driven by the per-sample strobe plus a debounced loop key. It records incoming samples, then plays them back with wrap-around, and can overdub (saturating read-modify-write). It owns every SRAM control pin, replacing the current tie-offs. Each sample gets one fixed-length access slot (read phase, then write phase), so output latency is constant in every mode.

---
 rtl/loop_sram_ctrl.sv | 128 ++++++++++++
 tb/tb_loop_sram_ctrl.sv | 125 ++++++++++++
 2 files changed

// File: rtl/loop_sram_ctrl.sv
// loop_sram_ctrl: single-track looper on external 16-bit SRAM (record, wrap-around play, saturating overdub).
module loop_sram_ctrl #(
  parameter int ADDR_W   = 20,
  parameter int MAX_LEN  = 2**ADDR_W,
  parameter int WAIT_CYC = 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_valid,
  input  logic signed [15:0]  i_data,
  input  logic                i_key,
  input  logic                i_overdub,
  output logic signed [15:0]  o_data,
  output logic                o_valid,
  output logic [1:0]          o_mode,
  output logic [ADDR_W-1:0]   o_loop_len,
  output logic                o_overrun,
  output logic [ADDR_W-1:0]   o_SRAM_ADDR,
  inout  wire  [15:0]         io_SRAM_DQ,
  output logic                o_SRAM_WE_N,
  output logic                o_SRAM_CE_N,
  output logic                o_SRAM_OE_N,
  output logic                o_SRAM_LB_N,
  output logic                o_SRAM_UB_N
);
  typedef enum logic [1:0] {A_IDLE, A_RD, A_WR, A_DONE} st_t;
  localparam logic [1:0] M_IDLE = 2'd0, M_REC = 2'd1, M_PLAY = 2'd2;
  st_t st;
  logic [1:0] mode, smode, mode_n;
  logic [ADDR_W-1:0] ptr, ptr_n;
  logic [ADDR_W:0] len, len_n;
  logic [7:0] cnt;
  logic kpend, done, cmd, last, sovd, dq_oe, wr_act;
  logic signed [15:0] sdata, rdata, dq_out;
  function automatic logic [15:0] sat16(input logic signed [16:0] s);
    return s > 17'sd32767 ? 16'h7fff : s < -17'sd32768 ? 16'h8000 : s[15:0];
  endfunction
  assign io_SRAM_DQ  = dq_oe ? dq_out : 16'bz;
  assign o_SRAM_LB_N = o_SRAM_CE_N;
  assign o_SRAM_UB_N = o_SRAM_CE_N;
  assign o_mode      = mode;
  assign o_loop_len  = len[ADDR_W-1:0];
  assign last        = cnt == 8'(WAIT_CYC);
  assign wr_act      = smode == M_REC || (smode == M_PLAY && sovd);
  // Pointer advance happens first; a command seen in the same cycle acts on the advanced state.
  always_comb begin
    done   = st == A_DONE;
    cmd    = done ? (kpend | i_key) : (st == A_IDLE && i_key && !i_valid);
    mode_n = mode;
    ptr_n  = ptr;
    len_n  = len;
    if (done && smode == M_REC) begin
      if (ptr == ADDR_W'(MAX_LEN - 1)) begin
        len_n  = (ADDR_W+1)'(MAX_LEN);
        ptr_n  = '0;
        mode_n = M_PLAY;
      end else ptr_n = ptr + 1'b1;
    end else if (done && smode == M_PLAY)
      ptr_n = ({1'b0, ptr} == len - 1'b1) ? '0 : ptr + 1'b1;
    if (cmd) begin
      if (mode_n == M_IDLE) mode_n = M_REC;
      else if (mode_n == M_REC) begin
        mode_n = ptr_n == '0 ? M_IDLE : M_PLAY;
        len_n  = ptr_n == '0 ? len_n : {1'b0, ptr_n};
      end else mode_n = M_IDLE;
      ptr_n = '0;
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      st          <= A_IDLE;
      mode        <= M_IDLE;
      smode       <= M_IDLE;
      ptr         <= '0;
      len         <= '0;
      cnt         <= '0;
      kpend       <= 1'b0;
      sovd        <= 1'b0;
      sdata       <= '0;
      rdata       <= '0;
      dq_out      <= '0;
      dq_oe       <= 1'b0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_overrun   <= 1'b0;
      o_SRAM_ADDR <= '0;
      o_SRAM_WE_N <= 1'b1;
      o_SRAM_CE_N <= 1'b1;
      o_SRAM_OE_N <= 1'b1;
    end else begin
      mode      <= mode_n;
      ptr       <= ptr_n;
      len       <= len_n;
      kpend     <= done ? 1'b0 : (i_key && (st != A_IDLE || i_valid)) ? 1'b1 : kpend;
      o_overrun <= o_overrun | (i_valid && st != A_IDLE);
      o_valid   <= st == A_WR && last;
      case (st)
        A_IDLE: if (i_valid) begin
          st          <= A_RD;
          cnt         <= '0;
          smode       <= mode;
          sdata       <= i_data;
          sovd        <= i_overdub;
          o_SRAM_ADDR <= ptr;
          o_SRAM_CE_N <= mode != M_PLAY;
          o_SRAM_OE_N <= mode != M_PLAY;
        end
        A_RD: if (last) begin
          st          <= A_WR;
          cnt         <= '0;
          rdata       <= io_SRAM_DQ;
          dq_out      <= smode == M_REC ? sdata : sat16({io_SRAM_DQ[15], io_SRAM_DQ} + {sdata[15], sdata});
          dq_oe       <= wr_act;
          o_SRAM_CE_N <= !wr_act;
          o_SRAM_WE_N <= !wr_act;
          o_SRAM_OE_N <= 1'b1;
        end else cnt <= cnt + 1'b1;
        A_WR: if (last) begin
          st          <= A_DONE;
          dq_oe       <= 1'b0;
          o_SRAM_CE_N <= 1'b1;
          o_SRAM_WE_N <= 1'b1;
          o_data      <= smode == M_PLAY ? rdata : 16'sd0;
        end else cnt <= cnt + 1'b1;
        default: st <= A_IDLE;
      endcase
    end
endmodule

// File: tb/tb_loop_sram_ctrl.sv
// tb_loop_sram_ctrl: scoreboard bench for loop_sram_ctrl with a behavioural SRAM on the bus.
module tb_loop_sram_ctrl;
  localparam int AW = 4;
  logic clk = 0, rst_n = 0, valid = 0, key = 0, ovd = 0;
  logic signed [15:0] din = 0;
  wire signed [15:0] dout;
  wire ovalid, overrun, we_n, ce_n, oe_n, lb_n, ub_n;
  wire [1:0] mode;
  wire [AW-1:0] len, addr;
  wire [15:0] dq;
  logic [15:0] mem [0:15];
  int cyc = 0, n_run = 0, n_fail = 0;
  int exp_q[$], lat_q[$];
  int vals[4] = '{100, -200, 300, -400};

  loop_sram_ctrl #(.ADDR_W(AW), .MAX_LEN(8), .WAIT_CYC(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_data(din), .i_key(key),
    .i_overdub(ovd), .o_data(dout), .o_valid(ovalid), .o_mode(mode), .o_loop_len(len),
    .o_overrun(overrun), .o_SRAM_ADDR(addr), .io_SRAM_DQ(dq), .o_SRAM_WE_N(we_n),
    .o_SRAM_CE_N(ce_n), .o_SRAM_OE_N(oe_n), .o_SRAM_LB_N(lb_n), .o_SRAM_UB_N(ub_n));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign dq = (!ce_n && !oe_n && we_n) ? mem[addr] : 16'bz;
  always @(posedge clk) if (!ce_n && !we_n) mem[addr] <= dq;

  task automatic chk(input string tag, input int got, input int exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) if (ovalid) begin
    chk("pending_at_valid", int'(exp_q.size() > 0), 1);
    if (exp_q.size() > 0) begin
      chk("o_data", int'(dout), exp_q.pop_front());
      chk("latency", cyc, lat_q.pop_front());
    end
  end

  task automatic send(input int d, input bit ov, input int e);
    @(posedge clk); #1;
    valid = 1; din = 16'(d); ovd = ov;
    exp_q.push_back(e); lat_q.push_back(cyc + 5);
    @(posedge clk); #1 valid = 0;
    repeat (7) @(posedge clk);
  endtask

  task automatic press();
    @(posedge clk); #1 key = 1;
    @(posedge clk); #1 key = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk); #1;
    chk("rst_we", we_n, 1); chk("rst_ce", ce_n, 1); chk("rst_oe", oe_n, 1);
    chk("rst_lb", lb_n, 1); chk("rst_ub", ub_n, 1); chk("rst_mode", mode, 0);
    chk("rst_valid", ovalid, 0); chk("rst_len", len, 0); chk("rst_overrun", overrun, 0);
    chk("rst_addr", addr, 0);
    @(negedge clk) rst_n = 1;
    // record 4 then play 6 with wrap
    press(); chk("mode_rec", mode, 1);
    for (int i = 0; i < 4; i++) send(vals[i], 0, 0);
    for (int i = 0; i < 4; i++) chk("mem_rec", int'($signed(mem[i])), vals[i]);
    press(); chk("mode_play", mode, 2); chk("len4", len, 4);
    for (int i = 0; i < 6; i++) send(0, 0, vals[i % 4]);
    press(); chk("mode_idle", mode, 0); chk("len_kept", len, 4);
    send(555, 0, 0);
    chk("idle_no_write", int'($signed(mem[0])), 100);
    // overdub saturation
    press(); send(30000, 0, 0); send(-30000, 0, 0);
    press(); chk("mode_play2", mode, 2); chk("len2", len, 2);
    send(10000, 1, 30000); send(-10000, 1, -30000);
    chk("sat_hi", int'($signed(mem[0])), 32767); chk("sat_lo", int'($signed(mem[1])), -32768);
    send(0, 0, 32767); send(5, 0, -32768);
    chk("no_ovd_keep", int'($signed(mem[1])), -32768);
    // overrun: second strobe two cycles into a slot
    @(posedge clk); #1 valid = 1; din = 7; ovd = 0;
    exp_q.push_back(32767); lat_q.push_back(cyc + 5);
    @(posedge clk); #1 valid = 0;
    @(posedge clk); #1 valid = 1;
    @(posedge clk); #1 valid = 0;
    chk("overrun", overrun, 1);
    repeat (7) @(posedge clk);
    // key mid-slot applies only after the slot's o_valid
    @(posedge clk); #1 valid = 1;
    exp_q.push_back(-32768); lat_q.push_back(cyc + 5);
    @(posedge clk); #1 valid = 0;
    @(posedge clk); #1 key = 1;
    @(posedge clk); #1 key = 0;
    chk("mode_mid_slot", mode, 2);
    repeat (2) @(posedge clk); #1;
    chk("valid_at_done", ovalid, 1); chk("mode_at_valid", mode, 2);
    @(posedge clk); #1 chk("mode_after_done", mode, 0);
    repeat (2) @(posedge clk);
    // auto-stop at MAX_LEN
    press();
    for (int i = 0; i < 8; i++) begin
      send((i + 1) * 11, 0, 0);
      if (i == 6) chk("still_rec", mode, 1);
    end
    chk("auto_play", mode, 2); chk("auto_len", len, 0 + 8 % 16);
    send(0, 0, 11);
    press(); chk("auto_idle", mode, 0);
    // reset during the write phase
    press();
    @(posedge clk); #1 valid = 1; din = 999;
    @(posedge clk); #1 valid = 0;
    repeat (2) @(posedge clk); #1;
    chk("wr_we_low", we_n, 0); chk("wr_ce_low", ce_n, 0);
    #2 rst_n = 0;
    #1 chk("rst_we_now", we_n, 1); chk("rst_ce_now", ce_n, 1); chk("rst_oe_now", oe_n, 1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    chk("post_mode", mode, 0); chk("post_len", len, 0); chk("post_overrun", overrun, 0);
    chk("write_abandoned", int'($signed(mem[0])), 11);
    repeat (10) @(posedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
